// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store path: store/load codes, FSM states, access sizing.
// Imported by the decoder, the LSU top and the lane-alignment helper.
package load_store_unit_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} size_e;

  // Illegal and empty requests both report SZ_NONE; callers separate them.
  function automatic size_e access_size(input logic [1:0] st, input logic [2:0] ld);
    size_e sz;
    sz = SZ_NONE;
    if (ld == LD_NONE) begin
      case (st)
        ST_SB:   sz = SZ_BYTE;
        ST_SH:   sz = SZ_HALF;
        ST_SW:   sz = SZ_WORD;
        default: sz = SZ_NONE;
      endcase
    end else if (st == ST_NONE) begin
      case (ld)
        LD_LB, LD_LBU: sz = SZ_BYTE;
        LD_LH, LD_LHU: sz = SZ_HALF;
        LD_LW:         sz = SZ_WORD;
        default:       sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_illegal(input logic [1:0] st, input logic [2:0] ld);
    return (st != ST_NONE && ld != LD_NONE) || ld == 3'b110 || ld == 3'b111;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory-bus and response signals of the load/store unit.
// master = the LSU itself; slave = the core/bus environment driving it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  mem_store;
  logic [2:0]  mem_load;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    input  req_valid, mem_store, mem_load, addr, wdata, rd, bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, resp_we, resp_rd, resp_data, resp_err
  );

  modport slave (
    output req_valid, mem_store, mem_load, addr, wdata, rd, bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, resp_we, resp_rd, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit_lsu_align.sv
// Byte-lane enables, store-data replication and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; follows the latched request fields.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  size_e       size,
  input  logic        ld_signed,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);
  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    be        = 4'b0000;
    wdata_rep = wdata;
    load_data = shifted;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, runs one bus access, pulses a response.
// Latency: errors/no-ops respond the cycle after accept; bus accesses respond the cycle after bus_ack.
// Backpressure: req_ready only in IDLE; a bus access aborts after TIMEOUT cycles without ack.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.master lsu
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  size_e         size_q;
  logic          is_load_q, signed_q;
  logic [31:0]   addr_q, wdata_q;
  logic [4:0]    rd_q;
  logic          resp_err_q, resp_we_q;
  logic [31:0]   resp_data_q;

  size_e       req_size;
  logic        req_none, req_bad;
  logic        in_bus, in_resp;
  logic [3:0]  be;
  logic [31:0] wdata_rep, load_data;

  always_comb begin
    req_size = access_size(lsu.mem_store, lsu.mem_load);
    req_none = (lsu.mem_store == ST_NONE) && (lsu.mem_load == LD_NONE);
    req_bad  = is_illegal(lsu.mem_store, lsu.mem_load) ||
               is_misaligned(req_size, lsu.addr[1:0]);
  end

  lsu_align u_align (
    .size      (size_q),
    .ld_signed (signed_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (lsu.bus_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      size_q      <= SZ_NONE;
      is_load_q   <= 1'b0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      resp_err_q  <= 1'b0;
      resp_we_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (lsu.req_valid) begin
          size_q      <= req_size;
          is_load_q   <= lsu.mem_load != LD_NONE;
          signed_q    <= lsu.mem_load == LD_LB || lsu.mem_load == LD_LH;
          addr_q      <= lsu.addr;
          wdata_q     <= lsu.wdata;
          rd_q        <= lsu.rd;
          cnt         <= '0;
          resp_err_q  <= req_bad;
          resp_we_q   <= 1'b0;
          resp_data_q <= '0;
          state       <= (req_none || req_bad) ? S_RESP : S_BUS;
        end
        // Ack is checked first so an ack on the expiry cycle still completes normally.
        S_BUS: if (lsu.bus_ack) begin
          state       <= S_RESP;
          resp_err_q  <= 1'b0;
          resp_we_q   <= is_load_q && rd_q != 5'd0;
          resp_data_q <= is_load_q ? load_data : 32'd0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state      <= S_RESP;
          resp_err_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_bus  = state == S_BUS;
  assign in_resp = state == S_RESP;

  assign lsu.req_ready  = state == S_IDLE;
  assign lsu.bus_req    = in_bus;
  assign lsu.bus_we     = in_bus && !is_load_q;
  assign lsu.bus_addr   = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
  assign lsu.bus_be     = in_bus ? be : 4'b0000;
  assign lsu.bus_wdata  = (in_bus && !is_load_q) ? wdata_rep : 32'd0;

  assign lsu.resp_valid = in_resp;
  assign lsu.resp_we    = in_resp && resp_we_q;
  assign lsu.resp_err   = in_resp && resp_err_q;
  assign lsu.resp_data  = in_resp ? resp_data_q : 32'd0;
  assign lsu.resp_rd    = rd_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, 256, max cycles bus_req is held without bus_ack before abort.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  unit can accept request.
REQ-007 mem_store  in  2  01 SB, 10 SH, 11 SW, 00 none.
REQ-008 mem_load  in  3  001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 000 none.
REQ-009 addr  in  32  byte address (rs1 + imm).
REQ-010 wdata  in  32  store data (rs2 value).
REQ-011 rd  in  5  load destination register.
REQ-012 bus_req  out  1  bus access request.
REQ-013 bus_we  out  1  1 write, 0 read.
REQ-014 bus_addr  out  32  word address, {addr[31:2],2'b00}.
REQ-015 bus_be  out  4  byte enables.
REQ-016 bus_wdata  out  32  lane-replicated store data.
REQ-017 bus_ack  in  1  access complete; bus_rdata valid same cycle.
REQ-018 bus_rdata  in  32  read word.
REQ-019 resp_valid  out  1  one-cycle completion pulse.
REQ-020 resp_we  out  1  write resp_data to reg_file[resp_rd].
REQ-021 resp_rd  out  5  destination register.
REQ-022 resp_data  out  32  extended load result.
REQ-023 resp_err  out  1  misaligned, illegal or timeout.

Function
REQ-024 FSM states IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-025 Accept on req_valid&&req_ready at edge T; operands, size code, addr[1:0], rd latched.
REQ-026 Legal aligned access: IDLE->BUS; bus_req=1 and bus_addr/bus_be/bus_we/bus_wdata stable from T+1 until the edge sampling bus_ack.
REQ-027 bus_ack in BUS: BUS->RESP; resp_valid=1 for exactly the next cycle, then RESP->IDLE; bus_req deasserts the cycle after ack.
REQ-028 Byte lanes: byte be=4'b0001<<addr[1:0]; half be=4'b0011<<{addr[1],1'b0}; word be=4'b1111; same for loads.
REQ-029 bus_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-030 Load result: bus_rdata shifted right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; captured at ack.
REQ-031 Misaligned (half with addr[0]=1; word with addr[1:0]!=0): no bus access; IDLE->RESP; resp_valid at T+1 with resp_err=1, resp_we=0.
REQ-032 Illegal: both codes nonzero, or mem_load in {110,111}: treated as misaligned (no bus, resp_err=1).
REQ-033 Both codes zero: no bus access; resp_valid at T+1, resp_err=0, resp_we=0.
REQ-034 resp_we=1 only for successful loads with rd!=0; stores always resp_we=0.
REQ-035 Timeout counter clears on entry to BUS; if TIMEOUT cycles elapse without ack: drop bus_req, ->RESP, resp_err=1, resp_we=0.
REQ-036 bus_ack on the same cycle as timeout expiry: ack wins, normal completion.
REQ-037 bus_ack outside BUS ignored; resp_data=0 on any non-load or error response.

Reset
REQ-038 rst at any edge: state=IDLE, counter=0; next cycle req_ready=1, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, resp_valid=0, resp_we=0, resp_err=0, resp_rd=0, resp_data=0.
REQ-039 Reset mid-BUS abandons the access; no response is ever produced for it.

Structure
REQ-040 Shared define header holds mem_store/mem_load encodings and FSM state constants, shared with the decoder.
REQ-041 Sub-module lsu_align: combinational bus_be/bus_wdata generation and load extraction/extension; FSM and counter in load_store_unit.

Verification
REQ-042 SB addr=0x1003 wdata=0xAB, ack after 2 cycles -> bus_addr=0x1000, be=1000, bus_wdata=0xABABABAB, resp_valid, resp_we=0.
REQ-043 LB addr=0x2001, rdata=0x0000_8000, rd=5 -> resp_data=0xFFFFFF80, resp_rd=5, resp_we=1; LBU same -> 0x00000080.
REQ-044 LW addr=0x2002 -> no bus_req, resp_valid at T+1, resp_err=1.
REQ-045 LH addr=0x10, ack never asserted, TIMEOUT=4 -> bus_req for 4 cycles, then resp_err=1, resp_we=0.
REQ-046 rst asserted during BUS -> bus_req=0 next cycle, no resp_valid, req_ready=1; a following SW completes normally.
